// File: rtl/axi4_lite_read_master_if.sv
// Purpose: bundles the core-side load port and the AXI4-Lite AR/R channels of one read initiator.
// Latency: none, wiring only.
// Backpressure: carries rd_ready (core side), M_AXI_ARREADY and M_AXI_RREADY (bus side).
// Ports / modports:
//   master - view of the read initiator: drives rd_ready/rd_data/rd_err/rd_done and AR*, RREADY
//   slave  - view of the environment (core + AXI slave): drives rd_req/rd_addr, ARREADY and R*
interface axi4_lite_read_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // core side
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic                  rd_done;
    // AXI4-Lite read channels
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [2:0]            M_AXI_ARPROT;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  rd_req, rd_addr,
        output rd_ready, rd_data, rd_err, rd_done,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output rd_req, rd_addr,
        input  rd_ready, rd_data, rd_err, rd_done,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_read_master.sv
// Purpose: single-outstanding AXI4-Lite read initiator turning a core load request into AR/R.
// Latency: rd_req accepted at edge 0 -> ARVALID cycle 1 -> RREADY cycle 2 -> rd_done cycle 3, +1 per wait.
// Backpressure: rd_ready low while busy (requests dropped, not queued); waits indefinitely on ARREADY/RVALID.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, abandons any read in flight without rd_done
//   io_rd - master modport: core load port (rd_*) and AXI4-Lite AR/R channels (M_AXI_*)
module axi4_lite_read_master #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] ARPROT_VAL = 3'b000
) (
    input  logic                           clk,
    input  logic                           rst,
    axi4_lite_read_master_if.master        io_rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_done;
    logic                  r_ready;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [DATA_WIDTH-1:0] r_data;

    state_t                w_state_nxt;
    logic                  w_arvalid_nxt;
    logic                  w_rready_nxt;
    logic                  w_done_nxt;
    logic                  w_ready_nxt;
    logic                  w_err_nxt;
    logic [ADDR_WIDTH-1:0] w_araddr_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_araddr_nxt = r_araddr;
        w_data_nxt   = r_data;
        w_err_nxt    = r_err;

        case (r_state)
            S_IDLE: begin
                if (io_rd.rd_req) begin
                    w_araddr_nxt = io_rd.rd_addr;
                    w_state_nxt  = S_ADDR;
                end
            end
            S_ADDR: begin
                // ARREADY may already have been high before ARVALID; it is taken here.
                if (io_rd.M_AXI_ARREADY) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (io_rd.M_AXI_RVALID) begin
                    w_data_nxt  = io_rd.M_AXI_RDATA;
                    // OKAY/EXOKAY are success; SLVERR/DECERR flag an error.
                    case (io_rd.M_AXI_RRESP)
                        2'b00, 2'b01: w_err_nxt = 1'b0;
                        default:      w_err_nxt = 1'b1;
                    endcase
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are a function of the next state so they come straight off flops.
        w_arvalid_nxt = (w_state_nxt == S_ADDR);
        w_rready_nxt  = (w_state_nxt == S_DATA);
        w_done_nxt    = (w_state_nxt == S_RESP);
        w_ready_nxt   = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_araddr  <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_done    <= w_done_nxt;
            r_ready   <= w_ready_nxt;
            r_err     <= w_err_nxt;
            r_araddr  <= w_araddr_nxt;
            r_data    <= w_data_nxt;
        end
    end

    assign io_rd.rd_ready      = r_ready;
    assign io_rd.rd_data       = r_data;
    assign io_rd.rd_err        = r_err;
    assign io_rd.rd_done       = r_done;
    assign io_rd.M_AXI_ARADDR  = r_araddr;
    assign io_rd.M_AXI_ARPROT  = ARPROT_VAL;
    assign io_rd.M_AXI_ARVALID = r_arvalid;
    assign io_rd.M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Purpose: directed bench for axi4_lite_read_master acting as core and AXI4-Lite read slave.
// Latency: checks exact cycle of ARVALID/RREADY/rd_done relative to request acceptance.
// Backpressure: drives ARREADY/RVALID wait states and busy-time requests.
module tb_axi4_lite_read_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi4_lite_read_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rd_if ();

    axi4_lite_read_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ARPROT_VAL(3'b000)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_rd (rd_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [32:0] sb_q[$];          // {rd_err, rd_data} expected per accepted read
    logic [31:0] last_data = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every rd_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rd_if.rd_done === 1'b1) begin
            logic [32:0] e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("spurious_rd_done", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_data", rd_if.rd_data, e[31:0]);
                chk("rd_err", rd_if.rd_err, e[32]);
            end
        end
    end

    // One full read: core request plus slave with ar_wait/r_wait wait states.
    task automatic read_txn(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input int ar_wait, input int r_wait, input bit hold);
        int cyc;
        int n;
        n = 0;
        while (rd_if.rd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("rd_ready_before_req", rd_if.rd_ready, 1'b1);
        rd_if.rd_req        = 1'b1;
        rd_if.rd_addr       = addr;
        rd_if.M_AXI_ARREADY = (ar_wait == 0);   // early ARREADY is legal
        sb_q.push_back({resp[1], data});
        step();
        cyc = 1;
        if (!hold) rd_if.rd_req = 1'b0;
        for (int k = 0; k <= ar_wait; k++) begin
            chk("arvalid_in_addr", rd_if.M_AXI_ARVALID, 1'b1);
            chk("araddr_stable", rd_if.M_AXI_ARADDR, addr);
            chk("rready_in_addr", rd_if.M_AXI_RREADY, 1'b0);
            chk("rd_ready_busy", rd_if.rd_ready, 1'b0);
            if (hold) rd_if.rd_addr = $urandom;
            rd_if.M_AXI_ARREADY = (k == ar_wait);
            step();
            cyc++;
        end
        rd_if.M_AXI_ARREADY = 1'b0;
        for (int k = 0; k <= r_wait; k++) begin
            chk("rready_in_data", rd_if.M_AXI_RREADY, 1'b1);
            chk("arvalid_in_data", rd_if.M_AXI_ARVALID, 1'b0);
            if (hold) rd_if.rd_addr = $urandom;
            rd_if.M_AXI_RVALID = (k == r_wait);
            rd_if.M_AXI_RDATA  = (k == r_wait) ? data : 32'hBAD0_0000;
            rd_if.M_AXI_RRESP  = (k == r_wait) ? resp : 2'b11;
            step();
            cyc++;
        end
        rd_if.M_AXI_RVALID = 1'b0;
        rd_if.rd_req       = 1'b0;
        chk("rd_done_pulse", rd_if.rd_done, 1'b1);
        chk("rd_done_cycle", cyc, ar_wait + r_wait + 3);
        chk("rready_in_resp", rd_if.M_AXI_RREADY, 1'b0);
        step();
        chk("rd_done_one_cycle", rd_if.rd_done, 1'b0);
        chk("rd_ready_after", rd_if.rd_ready, 1'b1);
        last_data = data;
    endtask

    logic [31:0] b2b_addr [8];
    logic [31:0] b2b_data [8];

    initial begin
        int dc;
        rd_if.rd_req        = 1'b0;
        rd_if.rd_addr       = 32'h0;
        rd_if.M_AXI_ARREADY = 1'b0;
        rd_if.M_AXI_RDATA   = 32'h0;
        rd_if.M_AXI_RRESP   = 2'b00;
        rd_if.M_AXI_RVALID  = 1'b0;

        // reset state
        #12;
        chk("rst_arvalid", rd_if.M_AXI_ARVALID, 1'b0);
        chk("rst_rready", rd_if.M_AXI_RREADY, 1'b0);
        chk("rst_rd_done", rd_if.rd_done, 1'b0);
        chk("rst_rd_err", rd_if.rd_err, 1'b0);
        chk("rst_rd_data", rd_if.rd_data, 32'h0);
        chk("rst_araddr", rd_if.M_AXI_ARADDR, 32'h0);
        chk("rst_rd_ready", rd_if.rd_ready, 1'b1);
        chk("arprot", rd_if.M_AXI_ARPROT, 3'b000);
        step();
        rst = 1'b0;
        step();

        // zero-wait read
        read_txn(32'h1000_0004, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0);
        // wait states: 3 on ARREADY, 2 on RVALID -> rd_done in cycle 8
        read_txn(32'h2000_0010, 32'hCAFE_F00D, 2'b00, 3, 2, 1'b0);

        // error responses then recovery
        read_txn(32'h3000_0000, 32'h0000_0000, 2'b10, 0, 1, 1'b0);
        read_txn(32'h3000_0004, 32'h1111_2222, 2'b00, 1, 0, 1'b0);
        read_txn(32'h3000_0008, 32'h3333_4444, 2'b11, 0, 0, 1'b0);
        read_txn(32'h3000_000C, 32'h5555_6666, 2'b01, 0, 0, 1'b0);

        // busy: rd_req held with changing address; only one transaction
        dc = done_cnt;
        read_txn(32'h4000_0040, 32'h0BAD_CAFE, 2'b00, 2, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("no_extra_arvalid", rd_if.M_AXI_ARVALID, 1'b0);
            step();
        end
        chk("one_txn_per_accept", done_cnt - dc, 1);

        // RVALID in IDLE is ignored
        dc = done_cnt;
        rd_if.M_AXI_RVALID = 1'b1;
        rd_if.M_AXI_RDATA  = 32'h1234_5678;
        rd_if.M_AXI_RRESP  = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_rready", rd_if.M_AXI_RREADY, 1'b0);
            chk("idle_rd_done", rd_if.rd_done, 1'b0);
            chk("idle_rd_ready", rd_if.rd_ready, 1'b1);
            chk("idle_rd_data_held", rd_if.rd_data, last_data);
            chk("idle_rd_err_held", rd_if.rd_err, 1'b0);
        end
        rd_if.M_AXI_RVALID = 1'b0;
        chk("idle_rvalid_no_done", done_cnt - dc, 0);

        // reset during DATA
        rd_if.rd_req        = 1'b1;
        rd_if.rd_addr       = 32'h5000_0000;
        rd_if.M_AXI_ARREADY = 1'b1;
        step();
        rd_if.rd_req = 1'b0;
        chk("pre_rst_arvalid", rd_if.M_AXI_ARVALID, 1'b1);
        step();
        rd_if.M_AXI_ARREADY = 1'b0;
        chk("pre_rst_rready", rd_if.M_AXI_RREADY, 1'b1);
        dc = done_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_arvalid", rd_if.M_AXI_ARVALID, 1'b0);
        chk("midrst_rready", rd_if.M_AXI_RREADY, 1'b0);
        chk("midrst_rd_ready", rd_if.rd_ready, 1'b1);
        chk("midrst_rd_done", rd_if.rd_done, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("midrst_no_done", done_cnt - dc, 0);
        chk("midrst_rd_data", rd_if.rd_data, 32'h0);
        read_txn(32'h5000_0004, 32'hFACE_B00C, 2'b00, 0, 0, 1'b0);

        // back-to-back reads against a table-driven slave
        b2b_addr = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C,
                     32'h0000_0100, 32'h0000_0104, 32'h8000_0000, 32'hFFFF_FFFC};
        b2b_data = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFF, 32'h0000_0001,
                     32'hA5A5_5A5A, 32'h5A5A_A5A5, 32'h8000_0001, 32'h7FFF_FFFE};
        dc = done_cnt;
        for (int i = 0; i < 8; i++) begin
            read_txn(b2b_addr[i], b2b_data[i], 2'b00, (i % 3 == 0) ? 0 : int'($urandom_range(0, 2)),
                     (i % 2 == 0) ? 0 : int'($urandom_range(0, 2)), 1'b0);
        end
        chk("b2b_done_count", done_cnt - dc, 8);

        step();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
